sos_coef_loader: RTL and testbench

Upstream control stage for the second-order recursive section.
- Accepts coefficient writes over a valid/ready port into a shadow bank.
- On a commit request, swaps the full set of four coefficients into the active bank atomically, on a sample boundary, so the section never runs with a mixed old/new set.
- Also produces the section's run enable, which stays low until the first complete set is applied.

---
 rtl/sos_coef_loader.sv | 122 ++++++++++++
 tb/tb_sos_coef_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sos_coef_loader.sv
// Coefficient loader for one second-order section: shadow bank written over valid/ready,
// swapped into the active bank atomically on a sample boundary after a commit.
module sos_coef_loader #(
   parameter int COEF_W    = 16,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [1:0]           wr_addr,
   input  logic [COEF_W-1:0]    wr_data,
   input  logic                 commit,
   input  logic                 sample_strobe,
   output logic [COEF_W-1:0]    a_1_1,
   output logic [COEF_W-1:0]    a_2_1,
   output logic [COEF_W-1:0]    b_1_1,
   output logic [COEF_W-1:0]    b_2_1,
   output logic                 filter_run,
   output logic                 pending,
   output logic                 commit_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      APPLY = 2'd2
   } state_t;

   state_t                state_q;
   logic [COEF_W-1:0]     shadow_q [4];
   logic [COEF_W-1:0]     active_q [4];
   logic [3:0]            mask_q;
   logic                  filter_run_q;
   logic                  commit_err_q;
   logic [ERR_CNT_W-1:0]  err_cnt_q;

   logic                  wr_fire;
   logic [3:0]            mask_d;
   logic                  mask_full;
   logic [ERR_CNT_W-1:0]  err_cnt_d;

   // Writes are only accepted in IDLE, so the shadow bank is frozen while a swap is in flight.
   assign wr_ready = (state_q == IDLE) && !reset;
   assign wr_fire  = wr_valid && wr_ready;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      mask_d    = mask_q;
      err_cnt_d = err_cnt_q;
      if (wr_fire) begin
         mask_d = mask_q | (4'b0001 << wr_addr);
      end
      if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
         err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // A write landing in the commit cycle counts towards completing the set.
   assign mask_full = &mask_d;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   // NOTE: the coefficient arrays are reset explicitly; the section must start from a known all-zero set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         mask_q       <= 4'b0000;
         filter_run_q <= 1'b0;
         commit_err_q <= 1'b0;
         err_cnt_q    <= '0;
         for (int i = 0; i < 4; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         commit_err_q <= 1'b0;
         if (wr_fire) begin
            shadow_q[wr_addr] <= wr_data;
         end
         case (state_q)
            IDLE: begin
               mask_q <= mask_d;
               if (commit) begin
                  if (mask_full) begin
                     state_q <= ARMED;
                  end else begin
                     commit_err_q <= 1'b1;
                     err_cnt_q    <= err_cnt_d;
                  end
               end
            end
            ARMED: begin
               if (sample_strobe) begin
                  state_q <= APPLY;
               end
            end
            APPLY: begin
               for (int i = 0; i < 4; i++) begin
                  active_q[i] <= shadow_q[i];
               end
               mask_q       <= 4'b0000;
               filter_run_q <= 1'b1;
               state_q      <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign pending    = (state_q != IDLE);
   assign a_1_1      = active_q[0];
   assign a_2_1      = active_q[1];
   assign b_1_1      = active_q[2];
   assign b_2_1      = active_q[3];
   assign filter_run = filter_run_q;
   assign commit_err = commit_err_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_sos_coef_loader.sv
// Directed bench for sos_coef_loader: write/commit/swap timing, rejected commits,
// simultaneous events, reset during a pending swap and error-counter saturation.
module tb_sos_coef_loader;

   localparam int COEF_W    = 16;
   localparam int ERR_CNT_W = 8;

   logic                 clk;
   logic                 reset;
   logic                 wr_valid;
   logic                 wr_ready;
   logic [1:0]           wr_addr;
   logic [COEF_W-1:0]    wr_data;
   logic                 commit;
   logic                 sample_strobe;
   logic [COEF_W-1:0]    a_1_1;
   logic [COEF_W-1:0]    a_2_1;
   logic [COEF_W-1:0]    b_1_1;
   logic [COEF_W-1:0]    b_2_1;
   logic                 filter_run;
   logic                 pending;
   logic                 commit_err;
   logic [ERR_CNT_W-1:0] err_cnt;

   int checks = 0;
   int errors = 0;

   sos_coef_loader #(.COEF_W(COEF_W), .ERR_CNT_W(ERR_CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .commit        (commit),
      .sample_strobe (sample_strobe),
      .a_1_1         (a_1_1),
      .a_2_1         (a_2_1),
      .b_1_1         (b_1_1),
      .b_2_1         (b_2_1),
      .filter_run    (filter_run),
      .pending       (pending),
      .commit_err    (commit_err),
      .err_cnt       (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [1:0] addr, input logic [COEF_W-1:0] data);
      wr_valid = 1'b1;
      wr_addr  = addr;
      wr_data  = data;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic pulse_commit();
      commit = 1'b1;
      tick();
      commit = 1'b0;
   endtask

   task automatic pulse_strobe();
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
   endtask

   task automatic check_coefs(input string tag, input logic [COEF_W-1:0] e0, input logic [COEF_W-1:0] e1,
                              input logic [COEF_W-1:0] e2, input logic [COEF_W-1:0] e3);
      check({tag, ".a_1_1"}, 32'(a_1_1), 32'(e0));
      check({tag, ".a_2_1"}, 32'(a_2_1), 32'(e1));
      check({tag, ".b_1_1"}, 32'(b_1_1), 32'(e2));
      check({tag, ".b_2_1"}, 32'(b_2_1), 32'(e3));
   endtask

   initial begin
      reset         = 1'b1;
      wr_valid      = 1'b0;
      wr_addr       = 2'd0;
      wr_data       = '0;
      commit        = 1'b0;
      sample_strobe = 1'b0;
      tick();
      tick();
      check("rst.wr_ready_low", 32'(wr_ready), 32'd0);
      reset = 1'b0;
      tick();

      // Reset state
      check_coefs("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check("rst.filter_run", 32'(filter_run), 32'd0);
      check("rst.wr_ready", 32'(wr_ready), 32'd1);
      check("rst.pending", 32'(pending), 32'd0);
      check("rst.err_cnt", 32'(err_cnt), 32'd0);

      // Full set, commit, strobe three cycles after commit
      write(2'd0, 16'h0100);
      write(2'd1, 16'hFF80);
      write(2'd2, 16'h0040);
      write(2'd3, 16'h0020);
      check_coefs("wr_no_effect", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      pulse_commit();
      check("t1.pending", 32'(pending), 32'd1);
      check("t1.wr_ready", 32'(wr_ready), 32'd0);
      check("t1.commit_err", 32'(commit_err), 32'd0);
      pulse_commit();
      check("t1.armed_commit_no_err", 32'(commit_err), 32'd0);
      tick();
      pulse_strobe();
      check("t1.apply_pending", 32'(pending), 32'd1);
      check_coefs("t1.apply_not_yet", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check("t1.apply_run_low", 32'(filter_run), 32'd0);
      tick();
      check_coefs("t1.swap", 16'h0100, 16'hFF80, 16'h0040, 16'h0020);
      check("t1.filter_run", 32'(filter_run), 32'd1);
      check("t1.wr_ready", 32'(wr_ready), 32'd1);
      check("t1.pending_done", 32'(pending), 32'd0);

      // Incomplete commit rejected, then completed
      write(2'd0, 16'h1111);
      write(2'd1, 16'h2222);
      pulse_commit();
      check("t2.commit_err", 32'(commit_err), 32'd1);
      check("t2.err_cnt", 32'(err_cnt), 32'd1);
      check("t2.pending", 32'(pending), 32'd0);
      check_coefs("t2.unchanged", 16'h0100, 16'hFF80, 16'h0040, 16'h0020);
      tick();
      check("t2.err_one_cycle", 32'(commit_err), 32'd0);
      write(2'd2, 16'h3333);
      write(2'd3, 16'h4444);
      pulse_commit();
      check("t2.accepted", 32'(pending), 32'd1);
      check("t2.no_err", 32'(commit_err), 32'd0);
      pulse_strobe();
      tick();
      check_coefs("t2.swap", 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      check("t2.err_cnt_kept", 32'(err_cnt), 32'd1);

      // Shadow persists but mask was cleared: a bare commit is rejected
      pulse_commit();
      check("t3.mask_cleared_err", 32'(commit_err), 32'd1);
      check("t3.err_cnt", 32'(err_cnt), 32'd2);
      check("t3.pending", 32'(pending), 32'd0);

      // Last write, commit and strobe all in one cycle
      write(2'd0, 16'h5555);
      write(2'd1, 16'h6666);
      write(2'd2, 16'h7777);
      wr_valid      = 1'b1;
      wr_addr       = 2'd3;
      wr_data       = 16'h8888;
      commit        = 1'b1;
      sample_strobe = 1'b1;
      tick();
      wr_valid      = 1'b0;
      commit        = 1'b0;
      sample_strobe = 1'b0;
      check("t4.accepted", 32'(pending), 32'd1);
      check("t4.no_err", 32'(commit_err), 32'd0);
      tick();
      tick();
      check("t4.still_armed", 32'(pending), 32'd1);
      check_coefs("t4.no_swap", 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      pulse_strobe();
      tick();
      check_coefs("t4.swap", 16'h5555, 16'h6666, 16'h7777, 16'h8888);
      check("t4.idle", 32'(pending), 32'd0);

      // Reset while ARMED abandons the swap
      write(2'd0, 16'h1234);
      write(2'd1, 16'h1234);
      write(2'd2, 16'h1234);
      write(2'd3, 16'h1234);
      pulse_commit();
      check("t5.armed", 32'(pending), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("t5.rst_wr_ready", 32'(wr_ready), 32'd0);
      check_coefs("t5.rst_async", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      tick();
      reset = 1'b0;
      tick();
      check("t5.pending", 32'(pending), 32'd0);
      check("t5.filter_run", 32'(filter_run), 32'd0);
      check("t5.err_cnt", 32'(err_cnt), 32'd0);
      pulse_strobe();
      pulse_strobe();
      tick();
      tick();
      check_coefs("t5.no_swap", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check("t5.still_idle", 32'(pending), 32'd0);
      check("t5.run_low", 32'(filter_run), 32'd0);

      // 300 incomplete commits saturate the error counter
      for (int i = 1; i <= 300; i++) begin
         commit = 1'b1;
         tick();
         if (i == 1)   check("t6.err_cnt_1", 32'(err_cnt), 32'h01);
         if (i == 254) check("t6.err_cnt_254", 32'(err_cnt), 32'hFE);
         if (i == 255) check("t6.err_cnt_255", 32'(err_cnt), 32'hFF);
      end
      commit = 1'b0;
      check("t6.err_pulse", 32'(commit_err), 32'd1);
      check("t6.saturated", 32'(err_cnt), 32'hFF);
      tick();
      check("t6.err_clear", 32'(commit_err), 32'd0);
      check("t6.hold", 32'(err_cnt), 32'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
